// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and constants for the memory-access stage.
// Holds the stage FSM encoding, the byte-lane mask constants used to decode
// load widths, and a small helper to classify an execute-stage result.
package mem_access_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_e;

  localparam logic [3:0] BE_W  = 4'b1111;
  localparam logic [3:0] BE_HL = 4'b0011;
  localparam logic [3:0] BE_HH = 4'b1100;
  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;

  // True when the execute result needs a data-bus transaction.
  function automatic logic is_mem_access(input logic [3:0] rden, input logic [3:0] wren);
    return (rden != 4'b0000) || (wren != 4'b0000);
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: data-bus request/response bundle between the memory-access
// stage (master) and the data memory or bus fabric (slave).
interface mem_access_if;

  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        dbus_err;

  modport master (
    output dbus_req,
    output dbus_we,
    output dbus_addr,
    output dbus_be,
    output dbus_wdata,
    input  dbus_gnt,
    input  dbus_rvalid,
    input  dbus_rdata,
    input  dbus_err
  );

  modport slave (
    input  dbus_req,
    input  dbus_we,
    input  dbus_addr,
    input  dbus_be,
    input  dbus_wdata,
    output dbus_gnt,
    output dbus_rvalid,
    output dbus_rdata,
    output dbus_err
  );

endinterface

// File: rtl/mem_access_load_align.sv
// mem_access_load_align: purely combinational load data aligner.
// Picks the half-word or byte lane named by the read mask out of the bus
// word, shifts it down to bit 0 and sign- or zero-extends it to 32 bits.
// A full-word mask or any mask that is not a recognised lane pattern passes
// the word through untouched.
module mem_access_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [3:0]  rden,
  input  logic        sext,
  output logic [31:0] result
);

  logic fill_h_lo;
  logic fill_h_hi;
  logic fill_b0;
  logic fill_b1;
  logic fill_b2;
  logic fill_b3;

  assign fill_h_lo = sext & rdata[15];
  assign fill_h_hi = sext & rdata[31];
  assign fill_b0   = sext & rdata[7];
  assign fill_b1   = sext & rdata[15];
  assign fill_b2   = sext & rdata[23];
  assign fill_b3   = sext & rdata[31];

  // Select the addressed field and extend it according to the mask.
  always_comb begin
    result = rdata;
    case (rden)
      BE_W:    result = rdata;
      BE_HL:   result = {{16{fill_h_lo}}, rdata[15:0]};
      BE_HH:   result = {{16{fill_h_hi}}, rdata[31:16]};
      BE_B0:   result = {{24{fill_b0}}, rdata[7:0]};
      BE_B1:   result = {{24{fill_b1}}, rdata[15:8]};
      BE_B2:   result = {{24{fill_b2}}, rdata[23:16]};
      BE_B3:   result = {{24{fill_b3}}, rdata[31:24]};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage sitting right after execute.
// Non-memory results pass to the write-back registers with one cycle of
// latency. Loads and stores run a single data-bus transaction; while it is
// outstanding the stage stalls the front of the pipeline and emits bubbles.
// Optional feature macro: MEM_BUS_ERR_EN -- when defined, a response flagged
// with dbus_err suppresses the load write-back and pulses mem_err for one
// cycle; when undefined dbus_err is ignored and mem_err stays 0.
module mem_access
  import mem_access_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   EX_rd,
  input  logic         EX_rd_vld,
  input  logic [31:0]  EX_x_rd,
  input  logic [31:0]  EX_MEM_addr,
  input  logic [3:0]   EX_MEM_rden,
  input  logic         EX_MEM_rden_SEXT,
  input  logic [3:0]   EX_MEM_wren,
  input  logic [31:0]  EX_MEM_wrdata,
  input  logic [11:0]  EX_csr,
  input  logic [31:0]  EX_x_csr,
  input  logic         EX_csr_vld,
  mem_access_if.master dbus,
  output logic [4:0]   MEM_rd,
  output logic         MEM_rd_vld,
  output logic [31:0]  MEM_x_rd,
  output logic [11:0]  MEM_csr,
  output logic [31:0]  MEM_x_csr,
  output logic         MEM_csr_vld,
  output logic         mem_stall,
  output logic         mem_err
);

  mem_state_e state_q;
  mem_state_e state_d;

  // Captured transaction, held for the whole bus access.
  logic [29:0] addr_q;
  logic [29:0] addr_d;
  logic [3:0]  be_q;
  logic [3:0]  be_d;
  logic        we_q;
  logic        we_d;
  logic [31:0] wdata_q;
  logic [31:0] wdata_d;
  logic [4:0]  rd_q;
  logic [4:0]  rd_d;
  logic        rd_vld_q;
  logic        rd_vld_d;
  logic        sext_q;
  logic        sext_d;
  logic [3:0]  rden_q;
  logic [3:0]  rden_d;

  // Write-back registers seen by the register file and CSR unit.
  logic [4:0]  mem_rd_q;
  logic [4:0]  mem_rd_d;
  logic        mem_rd_vld_q;
  logic        mem_rd_vld_d;
  logic [31:0] mem_x_rd_q;
  logic [31:0] mem_x_rd_d;
  logic [11:0] mem_csr_q;
  logic [11:0] mem_csr_d;
  logic [31:0] mem_x_csr_q;
  logic [31:0] mem_x_csr_d;
  logic        mem_csr_vld_q;
  logic        mem_csr_vld_d;
  logic        mem_err_q;
  logic        mem_err_d;

  logic        ex_access;
  logic        ex_load;
  logic        complete;
  logic        bus_err;
  logic [31:0] load_data;

  logic [1:0]  unused_addr_lsb;

  assign unused_addr_lsb = EX_MEM_addr[1:0];

  assign ex_access = is_mem_access(EX_MEM_rden, EX_MEM_wren);
  assign ex_load   = (EX_MEM_rden != 4'b0000);

  // A transaction finishes on a response, either together with the grant
  // or later while waiting in RESP.
  assign complete = ((state_q == MEM_REQ) && dbus.dbus_gnt && dbus.dbus_rvalid) ||
                    ((state_q == MEM_RESP) && dbus.dbus_rvalid);

`ifdef MEM_BUS_ERR_EN
  assign bus_err = complete & dbus.dbus_err;
`else
  logic unused_bus_err;
  assign unused_bus_err = dbus.dbus_err;
  assign bus_err = 1'b0;
`endif

  mem_access_load_align u_load_align (
    .rdata  (dbus.dbus_rdata),
    .rden   (rden_q),
    .sext   (sext_q),
    .result (load_data)
  );

  // FSM state register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MEM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start on an access, wait for grant, then for response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: begin
        if (ex_access) begin
          state_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (dbus.dbus_gnt) begin
          state_d = dbus.dbus_rvalid ? MEM_IDLE : MEM_RESP;
        end
      end
      MEM_RESP: begin
        if (dbus.dbus_rvalid) begin
          state_d = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // FSM outputs: request and stall decoded from the registered state only.
  always_comb begin
    dbus.dbus_req   = (state_q == MEM_REQ);
    dbus.dbus_we    = we_q;
    dbus.dbus_addr  = {addr_q, 2'b00};
    dbus.dbus_be    = be_q;
    dbus.dbus_wdata = wdata_q;
    mem_stall       = (state_q != MEM_IDLE);
  end

  // Datapath next values: pass-through, capture, bubble or completion.
  always_comb begin
    addr_d        = addr_q;
    be_d          = be_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    rd_d          = rd_q;
    rd_vld_d      = rd_vld_q;
    sext_d        = sext_q;
    rden_d        = rden_q;
    mem_rd_d      = mem_rd_q;
    mem_rd_vld_d  = mem_rd_vld_q;
    mem_x_rd_d    = mem_x_rd_q;
    mem_csr_d     = mem_csr_q;
    mem_x_csr_d   = mem_x_csr_q;
    mem_csr_vld_d = mem_csr_vld_q;
    mem_err_d     = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (!ex_access) begin
          mem_rd_d      = EX_rd;
          mem_rd_vld_d  = EX_rd_vld;
          mem_x_rd_d    = EX_x_rd;
          mem_csr_d     = EX_csr;
          mem_x_csr_d   = EX_x_csr;
          mem_csr_vld_d = EX_csr_vld;
        end else begin
          addr_d        = EX_MEM_addr[31:2];
          we_d          = !ex_load;
          be_d          = ex_load ? EX_MEM_rden : EX_MEM_wren;
          wdata_d       = EX_MEM_wrdata;
          rd_d          = EX_rd;
          rd_vld_d      = EX_rd_vld;
          sext_d        = EX_MEM_rden_SEXT;
          rden_d        = EX_MEM_rden;
          mem_rd_vld_d  = 1'b0;
          mem_csr_vld_d = 1'b0;
        end
      end
      MEM_REQ, MEM_RESP: begin
        mem_rd_vld_d  = 1'b0;
        mem_csr_vld_d = 1'b0;
        if (complete) begin
          mem_err_d = bus_err;
          if (!we_q) begin
            mem_rd_d     = rd_q;
            mem_x_rd_d   = load_data;
            mem_rd_vld_d = rd_vld_q & ~bus_err;
          end
        end
      end
      default: begin
        mem_rd_vld_d  = 1'b0;
        mem_csr_vld_d = 1'b0;
      end
    endcase
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q        <= '0;
      be_q          <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      rd_q          <= '0;
      rd_vld_q      <= 1'b0;
      sext_q        <= 1'b0;
      rden_q        <= '0;
      mem_rd_q      <= '0;
      mem_rd_vld_q  <= 1'b0;
      mem_x_rd_q    <= '0;
      mem_csr_q     <= '0;
      mem_x_csr_q   <= '0;
      mem_csr_vld_q <= 1'b0;
      mem_err_q     <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      be_q          <= be_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      rd_q          <= rd_d;
      rd_vld_q      <= rd_vld_d;
      sext_q        <= sext_d;
      rden_q        <= rden_d;
      mem_rd_q      <= mem_rd_d;
      mem_rd_vld_q  <= mem_rd_vld_d;
      mem_x_rd_q    <= mem_x_rd_d;
      mem_csr_q     <= mem_csr_d;
      mem_x_csr_q   <= mem_x_csr_d;
      mem_csr_vld_q <= mem_csr_vld_d;
      mem_err_q     <= mem_err_d;
    end
  end

  assign MEM_rd      = mem_rd_q;
  assign MEM_rd_vld  = mem_rd_vld_q;
  assign MEM_x_rd    = mem_x_rd_q;
  assign MEM_csr     = mem_csr_q;
  assign MEM_x_csr   = mem_x_csr_q;
  assign MEM_csr_vld = mem_csr_vld_q;
  assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench for the memory-access stage.
// The stimulus side drives execute results and plays the bus slave; it
// pushes the expected bus request and write-backs into queues, and a
// monitor on the falling edge pops and compares whatever the stage emits.
// Honours MEM_BUS_ERR_EN when computing expected results.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  EX_rd;
  logic        EX_rd_vld;
  logic [31:0] EX_x_rd;
  logic [31:0] EX_MEM_addr;
  logic [3:0]  EX_MEM_rden;
  logic        EX_MEM_rden_SEXT;
  logic [3:0]  EX_MEM_wren;
  logic [31:0] EX_MEM_wrdata;
  logic [11:0] EX_csr;
  logic [31:0] EX_x_csr;
  logic        EX_csr_vld;
  logic [4:0]  MEM_rd;
  logic        MEM_rd_vld;
  logic [31:0] MEM_x_rd;
  logic [11:0] MEM_csr;
  logic [31:0] MEM_x_csr;
  logic        MEM_csr_vld;
  logic        mem_stall;
  logic        mem_err;

`ifdef MEM_BUS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] x_rd;
  } wb_exp_t;

  typedef struct {
    logic [11:0] csr;
    logic [31:0] x_csr;
  } csr_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic        rd_vld;
    logic [31:0] x_rd;
    logic [31:0] addr;
    logic [3:0]  rden;
    logic        sext;
    logic [3:0]  wren;
    logic [31:0] wdata;
    logic [11:0] csr;
    logic [31:0] x_csr;
    logic        csr_vld;
    logic [31:0] rdata;
    logic        err;
    int          gnt_delay;
    int          resp_delay;
  } instr_t;

  wb_exp_t  wb_q[$];
  csr_exp_t csr_q[$];
  bus_exp_t bus_q[$];

  int checks = 0;
  int errors = 0;
  int exp_err_count = 0;
  int obs_err_count = 0;

  mem_access_if dbus_if ();

  mem_access dut (
    .clk              (clk),
    .rst              (rst),
    .EX_rd            (EX_rd),
    .EX_rd_vld        (EX_rd_vld),
    .EX_x_rd          (EX_x_rd),
    .EX_MEM_addr      (EX_MEM_addr),
    .EX_MEM_rden      (EX_MEM_rden),
    .EX_MEM_rden_SEXT (EX_MEM_rden_SEXT),
    .EX_MEM_wren      (EX_MEM_wren),
    .EX_MEM_wrdata    (EX_MEM_wrdata),
    .EX_csr           (EX_csr),
    .EX_x_csr         (EX_x_csr),
    .EX_csr_vld       (EX_csr_vld),
    .dbus             (dbus_if),
    .MEM_rd           (MEM_rd),
    .MEM_rd_vld       (MEM_rd_vld),
    .MEM_x_rd         (MEM_x_rd),
    .MEM_csr          (MEM_csr),
    .MEM_x_csr        (MEM_x_csr),
    .MEM_csr_vld      (MEM_csr_vld),
    .mem_stall        (mem_stall),
    .mem_err          (mem_err)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference load extraction: field position from the lowest set lane,
  // field width from the number of set lanes.
  function automatic logic [31:0] ref_align(input logic [31:0] rdata, input logic [3:0] rden, input logic sext);
    int n;
    int lo;
    int width;
    logic [31:0] m;
    logic [31:0] v;
    n = $countones(rden);
    if (!((n == 1) || (rden == 4'b0011) || (rden == 4'b1100))) return rdata;
    lo = 0;
    while (lo < 4 && !rden[lo]) lo++;
    width = 8 * n;
    m = (32'h1 << width) - 32'h1;
    v = (rdata >> (8 * lo)) & m;
    if (sext && v[width-1]) v = v | ~m;
    return v;
  endfunction

  task automatic set_idle();
    EX_rd            = '0;
    EX_rd_vld        = 1'b0;
    EX_x_rd          = '0;
    EX_MEM_addr      = '0;
    EX_MEM_rden      = '0;
    EX_MEM_rden_SEXT = 1'b0;
    EX_MEM_wren      = '0;
    EX_MEM_wrdata    = '0;
    EX_csr           = '0;
    EX_x_csr         = '0;
    EX_csr_vld       = 1'b0;
  endtask

  // Present one execute result and, for an access, play the bus slave
  // until the transaction completes. Returns 1 unit after the edge where
  // the result lands in the write-back registers.
  task automatic apply_stimulus(input instr_t in);
    bit       is_load;
    bit       is_access;
    bit       exp_err;
    bit       exp_vld;
    bus_exp_t bexp;
    is_load   = (in.rden != 4'b0000);
    is_access = is_load || (in.wren != 4'b0000);
    EX_rd            = in.rd;
    EX_rd_vld        = in.rd_vld;
    EX_x_rd          = in.x_rd;
    EX_MEM_addr      = in.addr;
    EX_MEM_rden      = in.rden;
    EX_MEM_rden_SEXT = in.sext;
    EX_MEM_wren      = in.wren;
    EX_MEM_wrdata    = in.wdata;
    EX_csr           = in.csr;
    EX_x_csr         = in.x_csr;
    EX_csr_vld       = in.csr_vld;
    if (!is_access) begin
      if (in.rd_vld) wb_q.push_back('{rd: in.rd, x_rd: in.x_rd});
      if (in.csr_vld) csr_q.push_back('{csr: in.csr, x_csr: in.x_csr});
      dbus_if.dbus_gnt    = ($urandom_range(0, 3) == 0);
      dbus_if.dbus_rvalid = ($urandom_range(0, 3) == 0);
      dbus_if.dbus_rdata  = $urandom;
      @(posedge clk); #1;
      dbus_if.dbus_gnt    = 1'b0;
      dbus_if.dbus_rvalid = 1'b0;
      check_output("stall_nonmem", 32'(mem_stall), 32'd0);
      return;
    end
    bexp.addr  = in.addr & 32'hFFFF_FFFC;
    bexp.be    = is_load ? in.rden : in.wren;
    bexp.we    = !is_load;
    bexp.wdata = in.wdata;
    bus_q.push_back(bexp);
    exp_err = ERR_EN && in.err;
    exp_vld = is_load && in.rd_vld && !exp_err;
    if (exp_vld) wb_q.push_back('{rd: in.rd, x_rd: ref_align(in.rdata, in.rden, in.sext)});
    if (exp_err) exp_err_count++;
    @(posedge clk); #1;
    check_output("stall_in_req", 32'(mem_stall), 32'd1);
    check_output("req_in_req", 32'(dbus_if.dbus_req), 32'd1);
    check_output("bubble_in_req", 32'(MEM_rd_vld), 32'd0);
    repeat (in.gnt_delay) begin
      @(posedge clk); #1;
    end
    dbus_if.dbus_gnt = 1'b1;
    if (in.resp_delay == 0) begin
      dbus_if.dbus_rvalid = 1'b1;
      dbus_if.dbus_rdata  = in.rdata;
      dbus_if.dbus_err    = in.err;
    end
    @(posedge clk); #1;
    dbus_if.dbus_gnt    = 1'b0;
    dbus_if.dbus_rvalid = 1'b0;
    dbus_if.dbus_err    = 1'b0;
    if (in.resp_delay > 0) begin
      repeat (in.resp_delay - 1) begin
        dbus_if.dbus_gnt   = 1'($urandom_range(0, 1));
        dbus_if.dbus_rdata = $urandom;
        dbus_if.dbus_err   = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      dbus_if.dbus_gnt = 1'b0;
      check_output("stall_in_resp", 32'(mem_stall), 32'd1);
      check_output("req_in_resp", 32'(dbus_if.dbus_req), 32'd0);
      dbus_if.dbus_rvalid = 1'b1;
      dbus_if.dbus_rdata  = in.rdata;
      dbus_if.dbus_err    = in.err;
      @(posedge clk); #1;
      dbus_if.dbus_rvalid = 1'b0;
      dbus_if.dbus_err    = 1'b0;
    end
    check_output("stall_after_done", 32'(mem_stall), 32'd0);
    check_output("rd_vld_after_done", 32'(MEM_rd_vld), 32'(exp_vld));
    check_output("mem_err_pulse", 32'(mem_err), 32'(exp_err));
  endtask

  function automatic instr_t rand_instr();
    instr_t r;
    int kind;
    logic [3:0] masks [8];
    masks = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0110};
    kind         = $urandom_range(0, 9);
    r.rd         = 5'($urandom);
    r.rd_vld     = 1'($urandom);
    r.x_rd       = $urandom;
    r.addr       = $urandom;
    r.sext       = 1'($urandom);
    r.wdata      = $urandom;
    r.csr        = 12'($urandom);
    r.x_csr      = $urandom;
    r.csr_vld    = 1'($urandom);
    r.rdata      = $urandom;
    r.err        = ($urandom_range(0, 3) == 0);
    r.gnt_delay  = $urandom_range(0, 3);
    r.resp_delay = $urandom_range(0, 4);
    r.rden       = '0;
    r.wren       = '0;
    if (kind >= 4 && kind <= 6) r.rden = masks[$urandom_range(0, 7)];
    if (kind == 7 || kind == 8) r.wren = 4'($urandom_range(1, 15));
    if (kind == 9) begin
      r.rden = masks[$urandom_range(0, 7)];
      r.wren = 4'($urandom_range(1, 15));
    end
    return r;
  endfunction

  function automatic instr_t blank_instr();
    instr_t r;
    r = '{rd: '0, rd_vld: 1'b0, x_rd: '0, addr: '0, rden: '0, sext: 1'b0, wren: '0,
          wdata: '0, csr: '0, x_csr: '0, csr_vld: 1'b0, rdata: '0, err: 1'b0,
          gnt_delay: 0, resp_delay: 0};
    return r;
  endfunction

  // Monitor: compare every write-back, CSR write and bus handshake the
  // stage presents against the oldest expectation in its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (MEM_rd_vld) begin
        checks++;
        if (wb_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL wb_unexpected: got rd=%0d x_rd=0x%08h, expected no write-back", MEM_rd, MEM_x_rd);
        end else begin
          wb_exp_t w;
          w = wb_q.pop_front();
          check_output("wb_rd", 32'(MEM_rd), 32'(w.rd));
          check_output("wb_x_rd", MEM_x_rd, w.x_rd);
        end
      end
      if (MEM_csr_vld) begin
        checks++;
        if (csr_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL csr_unexpected: got csr=0x%03h, expected no CSR write", MEM_csr);
        end else begin
          csr_exp_t c;
          c = csr_q.pop_front();
          check_output("csr_addr", 32'(MEM_csr), 32'(c.csr));
          check_output("csr_data", MEM_x_csr, c.x_csr);
        end
      end
      if (dbus_if.dbus_req && dbus_if.dbus_gnt) begin
        checks++;
        if (bus_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL bus_unexpected: got addr=0x%08h, expected no request", dbus_if.dbus_addr);
        end else begin
          bus_exp_t b;
          b = bus_q.pop_front();
          check_output("bus_addr", dbus_if.dbus_addr, b.addr);
          check_output("bus_be", 32'(dbus_if.dbus_be), 32'(b.be));
          check_output("bus_we", 32'(dbus_if.dbus_we), 32'(b.we));
          if (b.we) check_output("bus_wdata", dbus_if.dbus_wdata, b.wdata);
        end
      end
      if (mem_err) obs_err_count++;
    end
  end

  // Main sequence: reset, directed cases, reset mid-transaction, random mix.
  initial begin
    instr_t in;
    rst = 1'b1;
    set_idle();
    dbus_if.dbus_gnt    = 1'b0;
    dbus_if.dbus_rvalid = 1'b0;
    dbus_if.dbus_rdata  = '0;
    dbus_if.dbus_err    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_req", 32'(dbus_if.dbus_req), 32'd0);
    check_output("reset_stall", 32'(mem_stall), 32'd0);
    check_output("reset_rd_vld", 32'(MEM_rd_vld), 32'd0);
    check_output("reset_csr_vld", 32'(MEM_csr_vld), 32'd0);
    check_output("reset_x_rd", MEM_x_rd, 32'd0);
    check_output("reset_mem_err", 32'(mem_err), 32'd0);
    rst = 1'b0;

    $display("[TB] non-memory pass-through");
    in = blank_instr();
    in.rd = 5'd5; in.rd_vld = 1'b1; in.x_rd = 32'h1234;
    apply_stimulus(in);
    check_output("pass_rd", 32'(MEM_rd), 32'd5);
    check_output("pass_rd_vld", 32'(MEM_rd_vld), 32'd1);
    check_output("pass_x_rd", MEM_x_rd, 32'h1234);
    check_output("pass_no_req", 32'(dbus_if.dbus_req), 32'd0);

    $display("[TB] signed byte load with delayed grant and response");
    in = blank_instr();
    in.rd = 5'd7; in.rd_vld = 1'b1; in.addr = 32'h103; in.rden = 4'b1000; in.sext = 1'b1;
    in.rdata = 32'h80FF_0000; in.gnt_delay = 1; in.resp_delay = 3;
    apply_stimulus(in);
    check_output("lb_x_rd", MEM_x_rd, 32'hFFFF_FF80);

    $display("[TB] unsigned half load, grant and response together");
    in = blank_instr();
    in.rd = 5'd9; in.rd_vld = 1'b1; in.addr = 32'h22; in.rden = 4'b1100;
    in.rdata = 32'hBEEF_1234;
    apply_stimulus(in);
    check_output("lhu_x_rd", MEM_x_rd, 32'h0000_BEEF);

    $display("[TB] byte store");
    in = blank_instr();
    in.rd = 5'd3; in.rd_vld = 1'b1; in.addr = 32'h41; in.wren = 4'b0010;
    in.wdata = 32'h5A5A_5A5A; in.gnt_delay = 2; in.resp_delay = 1;
    apply_stimulus(in);

    $display("[TB] word load with error response");
    in = blank_instr();
    in.rd = 5'd11; in.rd_vld = 1'b1; in.addr = 32'h200; in.rden = 4'b1111;
    in.rdata = 32'hCAFE_F00D; in.err = 1'b1; in.resp_delay = 2;
    apply_stimulus(in);

    $display("[TB] reset while waiting for a response");
    EX_rd = 5'd12; EX_rd_vld = 1'b1; EX_MEM_addr = 32'h300; EX_MEM_rden = 4'b1111;
    bus_q.push_back('{addr: 32'h300, be: 4'b1111, we: 1'b0, wdata: 32'h0});
    @(posedge clk); #1;
    dbus_if.dbus_gnt = 1'b1;
    @(posedge clk); #1;
    dbus_if.dbus_gnt = 1'b0;
    check_output("resp_before_reset", 32'(mem_stall), 32'd1);
    rst = 1'b1;
    #1;
    check_output("reset_drops_req", 32'(dbus_if.dbus_req), 32'd0);
    check_output("reset_drops_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    set_idle();
    rst = 1'b0;
    dbus_if.dbus_rvalid = 1'b1;
    dbus_if.dbus_rdata  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dbus_if.dbus_rvalid = 1'b0;
    check_output("late_rvalid_stall", 32'(mem_stall), 32'd0);
    check_output("late_rvalid_rd_vld", 32'(MEM_rd_vld), 32'd0);
    check_output("late_rvalid_x_rd", MEM_x_rd, 32'd0);

    $display("[TB] random mix");
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(rand_instr());
    end

    set_idle();
    repeat (3) @(posedge clk);
    #1;
    check_output("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    check_output("csr_queue_drained", 32'(csr_q.size()), 32'd0);
    check_output("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    check_output("mem_err_count", 32'(obs_err_count), 32'(exp_err_count));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
